audio_sample_fifo: RTL and testbench
====================================

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning sample width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries; it SHALL be a power of two and at least 4.
REQ-003 Port AUD_XCK  in  1  is the single clock (codec master clock); all logic SHALL be clocked on its rising edge.
REQ-004 Port reset_n  in  1  is the asynchronous, active-low reset.
REQ-005 Port in_data  in  DATA_W  is the producer sample, two's complement.
REQ-006 Port in_valid  in  1  means the producer offers in_data.
REQ-007 Port in_ready  out  1  means the FIFO accepts a sample this cycle.
REQ-008 Port AUD_LRCK  in  1  is the frame clock from the I2S transmitter, synchronous to AUD_XCK.
REQ-009 Port audiodata  out  DATA_W  is the sample presented to the I2S transmitter.
REQ-010 Port fifo_level  out  $clog2(DEPTH)+1  is the current entry count.
REQ-011 Port underrun_cnt  out  8  is the saturating count of underrun events.
REQ-012 Port clr_underrun  in  1  is a synchronous clear of underrun_cnt.

Function
REQ-013 Push SHALL occur when in_valid && in_ready; in_ready SHALL be registered-derived: fifo_level < DEPTH.
REQ-014 lrck_q SHALL register AUD_LRCK each cycle; lr_edge SHALL be AUD_LRCK ^ lrck_q; lr_rise SHALL be AUD_LRCK && !lrck_q.
REQ-015 State machine SHALL have states PRIME and RUN.
REQ-016 PRIME: audiodata SHALL hold 0, no pops; transition to RUN SHALL occur on lr_rise when fifo_level >= DEPTH/2.
REQ-017 RUN: on each lr_edge with fifo_level > 0, one entry SHALL be popped and registered into audiodata the next cycle (1-cycle latency after lr_edge).
REQ-018 RUN: on lr_edge with fifo_level == 0, audiodata SHALL become 0, underrun_cnt SHALL increment (saturating at 255), and state SHALL return to PRIME.
REQ-019 Simultaneous push and pop SHALL both take effect; fifo_level unchanged.
REQ-020 Push into an empty FIFO in the same cycle as lr_edge SHALL NOT bypass; it SHALL count as an underrun.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; fifo_level SHALL never exceed DEPTH or go below 0.
REQ-022 clr_underrun coincident with an underrun event SHALL leave underrun_cnt at 0.
REQ-023 audiodata SHALL change only in the cycle after an lr_edge or on PRIME entry, never mid-frame.

Reset
REQ-024 While reset_n is low: state PRIME, pointers 0, fifo_level 0, audiodata 0, underrun_cnt 0, lrck_q 0, in_ready 0 during reset then 1 after release.
REQ-025 Reset asserted mid-frame SHALL discard all buffered samples; the block restarts priming after release.

Configuration
REQ-026 Macro AUDIO_VOLUME_EN: when defined, input port vol_shift (3 bits) SHALL exist and the popped sample SHALL be arithmetically right-shifted by vol_shift (sign preserved) before loading audiodata.
REQ-027 Without AUDIO_VOLUME_EN, vol_shift SHALL not exist and samples SHALL pass unmodified.

Structure
REQ-028 Package audio_pkg SHALL hold AUDIO_DATA_W (16), the state typedef {PRIME, RUN}, and UNDERRUN_MAX (255).
REQ-029 Storage and pointers SHALL be a sub-module sync_fifo (DATA_W, DEPTH parameters, push/pop/level); FSM, edge detect, volume and counter stay in the top.

Verification
REQ-030 Push 8 samples 0x1000..0x1007 with LRCK idle -> fifo_level 8, audiodata 0, state PRIME.
REQ-031 Then toggle AUD_LRCK 0->1 -> RUN; audiodata = 0x1000 two cycles after the LRCK change; next falling edge -> 0x1001.
REQ-032 Push 16 samples with no LRCK edges -> in_ready 0 at level 16; 17th in_valid not accepted; level stays 16.
REQ-033 Drain FIFO in RUN, one more lr_edge -> audiodata 0, underrun_cnt 1, state PRIME; assert clr_underrun -> 0.
REQ-034 With AUDIO_VOLUME_EN, vol_shift=2, sample 0x8000 -> audiodata 0xE000; sample 0x4000 -> 0x1000.
REQ-035 Pulse reset_n low mid-frame with level 10 -> level 0, audiodata 0, underrun_cnt 0 immediately (asynchronous).

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the audio sample FIFO
//
// AUDIO_DATA_W : default sample width in bits
// fifo_state_t : playback state, PRIME (filling, output muted) or RUN (playing)
// UNDERRUN_MAX : saturation value of the underrun event counter
package audio_pkg;

    localparam int AUDIO_DATA_W = 16;
    localparam int UNDERRUN_MAX = 255;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } fifo_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock sample FIFO with registered read data
//
// Ports:
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset, empties the FIFO
//   push      : write push_data (ignored when full)
//   push_data : sample to store
//   pop       : advance read pointer and register the head into pop_data
//               (ignored when empty)
//   pop_data  : head sample captured by the most recent pop
//   level     : current entry count, 0..DEPTH
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Guards keep level inside 0..DEPTH even if a caller misbehaves.
    assign do_push = push && (level != (AW + 1)'(DEPTH));
    assign do_pop  = pop && (level != '0);

    // Storage is not reset: stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            pop_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pop_data <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - sample FIFO feeding an I2S transmitter, paced by LRCK
//
// Optional feature macro: AUDIO_VOLUME_EN (adds vol_shift attenuation input)
//
// Ports:
//   AUD_XCK      : codec master clock, all logic on its rising edge
//   reset_n      : asynchronous active-low reset
//   vol_shift    : (AUDIO_VOLUME_EN only) arithmetic right shift applied to samples
//   in_data      : producer sample, two's complement
//   in_valid     : producer offers in_data
//   in_ready     : FIFO accepts a sample this cycle
//   AUD_LRCK     : frame clock from the I2S transmitter
//   audiodata    : sample presented to the transmitter
//   fifo_level   : current entry count
//   underrun_cnt : saturating count of underrun events
//   clr_underrun : synchronous clear of underrun_cnt
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DATA_W = AUDIO_DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic                     AUD_XCK,
    input  logic                     reset_n,
`ifdef AUDIO_VOLUME_EN
    input  logic [2:0]               vol_shift,
`endif
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     AUD_LRCK,
    output logic [DATA_W-1:0]        audiodata,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               underrun_cnt,
    input  logic                     clr_underrun
);

    localparam int LW = $clog2(DEPTH) + 1;

    fifo_state_t        state;
    logic               lrck_q;
    logic               lr_edge;
    logic               lr_rise;
    logic               ready_en;
    logic               load_q;
    logic               push;
    logic               pop;
    logic               start;
    logic               underrun_evt;
    logic [DATA_W-1:0]  pop_data;
    logic [DATA_W-1:0]  scaled;

    assign lr_edge = AUD_LRCK ^ lrck_q;
    assign lr_rise = AUD_LRCK && !lrck_q;

    // ready_en holds in_ready low throughout reset and for the release cycle.
    assign in_ready = ready_en && (fifo_level < LW'(DEPTH));
    assign push     = in_valid && in_ready;

    // The rising edge that ends priming also consumes the first sample, so
    // the left slot of that frame already carries real data.
    assign start        = (state == PRIME) && lr_rise && (fifo_level >= LW'(DEPTH / 2));
    assign pop          = start || ((state == RUN) && lr_edge && (fifo_level != '0));
    // Level is the pre-push count, so a push landing on the edge cannot bypass.
    assign underrun_evt = (state == RUN) && lr_edge && (fifo_level == '0);

`ifdef AUDIO_VOLUME_EN
    assign scaled = $signed(pop_data) >>> vol_shift;
`else
    assign scaled = pop_data;
`endif

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (AUD_XCK),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .level     (fifo_level)
    );

    always_ff @(posedge AUD_XCK or negedge reset_n) begin
        if (!reset_n) begin
            state        <= PRIME;
            lrck_q       <= 1'b0;
            ready_en     <= 1'b0;
            load_q       <= 1'b0;
            audiodata    <= '0;
            underrun_cnt <= '0;
        end else begin
            lrck_q   <= AUD_LRCK;
            ready_en <= 1'b1;
            // pop_data becomes valid the cycle after the pop; load it then.
            load_q   <= pop;

            case (state)
                PRIME: if (start)        state <= RUN;
                RUN:   if (underrun_evt) state <= PRIME;
                default:                 state <= PRIME;
            endcase

            if (underrun_evt) begin
                audiodata <= '0;
            end else if (load_q) begin
                audiodata <= scaled;
            end

            if (clr_underrun) begin
                underrun_cnt <= '0;
            end else if (underrun_evt && (underrun_cnt != 8'(UNDERRUN_MAX))) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb/tb_audio_sample_fifo.sv - randomized self-checking bench for audio_sample_fifo
module tb_audio_sample_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              AUD_XCK = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              AUD_LRCK;
    logic [DATA_W-1:0] audiodata;
    logic [LW-1:0]     fifo_level;
    logic [7:0]        underrun_cnt;
    logic              clr_underrun;
`ifdef AUDIO_VOLUME_EN
    logic [2:0]        vol_shift = 3'd0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 AUD_XCK = ~AUD_XCK;

    audio_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .AUD_XCK      (AUD_XCK),
        .reset_n      (reset_n),
`ifdef AUDIO_VOLUME_EN
        .vol_shift    (vol_shift),
`endif
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .AUD_LRCK     (AUD_LRCK),
        .audiodata    (audiodata),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt),
        .clr_underrun (clr_underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of buffered samples, a playing flag, the
    // sample fetched at the last frame edge (shown one cycle later), and
    // an event counter. It advances once per clock using the inputs that
    // the coming rising edge will sample.
    logic [DATA_W-1:0] m_q[$];
    bit                m_playing;
    bit                m_started;
    bit                m_prev_lr;
    bit                m_pend_vld;
    logic [DATA_W-1:0] m_pend;
    logic [DATA_W-1:0] m_audio;
    int                m_cnt;

    always @(negedge AUD_XCK) begin
        if (!reset_n) begin
            m_q.delete();
            m_playing  = 0;
            m_started  = 0;
            m_prev_lr  = 0;
            m_pend_vld = 0;
            m_audio    = '0;
            m_cnt      = 0;
        end else begin
            bit ready, edge_seen, rise_seen, take, und, acc;
            int lvl;
            lvl   = m_q.size();
            ready = m_started && (lvl < DEPTH);
            check("level", 32'(fifo_level), 32'(lvl));
            check("in_ready", 32'(in_ready), 32'(ready));
            check("audiodata", 32'(audiodata), 32'(m_audio));
            check("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));

            acc       = in_valid && ready;
            edge_seen = (AUD_LRCK != m_prev_lr);
            rise_seen = AUD_LRCK && !m_prev_lr;
            take = 0;
            und  = 0;
            if (!m_playing) begin
                if (rise_seen && lvl >= DEPTH / 2) begin
                    m_playing = 1;
                    take = 1;
                end
            end else if (edge_seen) begin
                if (lvl > 0) take = 1;
                else begin
                    und = 1;
                    m_playing = 0;
                end
            end
            if (und) m_audio = '0;
            else if (m_pend_vld) begin
`ifdef AUDIO_VOLUME_EN
                m_audio = $signed(m_pend) >>> vol_shift;
`else
                m_audio = m_pend;
`endif
            end
            m_pend_vld = take;
            if (take) m_pend = m_q.pop_front();
            if (acc) m_q.push_back(in_data);
            if (clr_underrun) m_cnt = 0;
            else if (und && m_cnt < 255) m_cnt++;
            m_prev_lr = AUD_LRCK;
            m_started = 1;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge AUD_XCK);
            #1;
        end
    endtask

    task automatic push_seq(input logic [DATA_W-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = first + DATA_W'(i);
            tick(1);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        in_data      = '0;
        in_valid     = 1'b0;
        AUD_LRCK     = 1'b0;
        clr_underrun = 1'b0;
        tick(3);
        check("rst level", 32'(fifo_level), 0);
        check("rst in_ready", 32'(in_ready), 0);
        check("rst audiodata", 32'(audiodata), 0);
        check("rst underrun", 32'(underrun_cnt), 0);
        reset_n = 1'b1;
        tick(2);
        check("ready after release", 32'(in_ready), 1);

        // Prime with 8 samples, LRCK idle: nothing plays.
        push_seq(16'h1000, 8);
        tick(1);
        check("primed level", 32'(fifo_level), 8);
        check("primed audio", 32'(audiodata), 0);

        // First rising edge starts playback, sample shows two edges later.
        AUD_LRCK = 1'b1;
        tick(1);
        check("audio before latency", 32'(audiodata), 0);
        tick(1);
        check("first sample", 32'(audiodata), 32'h1000);
        tick(2);
        AUD_LRCK = 1'b0;
        tick(2);
        check("second sample", 32'(audiodata), 32'h1001);
        tick(2);

        // Drain the remaining six, then one more edge underruns.
        for (int i = 0; i < 7; i++) begin
            AUD_LRCK = ~AUD_LRCK;
            tick(4);
        end
        check("underrun audio", 32'(audiodata), 0);
        check("underrun count", 32'(underrun_cnt), 1);
        check("underrun level", 32'(fifo_level), 0);
        clr_underrun = 1'b1;
        tick(1);
        clr_underrun = 1'b0;
        check("cleared count", 32'(underrun_cnt), 0);

        // Overfill in PRIME: the 17th offer is refused.
        push_seq(16'h2000, 17);
        check("full level", 32'(fifo_level), 16);
        check("full in_ready", 32'(in_ready), 0);

        // Randomized traffic at three fill rates.
        for (int phase = 0; phase < 3; phase++) begin
            int gap;
            int pct;
            gap = 4;
            pct = (phase == 0) ? 15 : (phase == 1) ? 5 : 40;
            for (int c = 0; c < 1200; c++) begin
                in_valid     = ($urandom_range(99) < pct);
                in_data      = DATA_W'($urandom);
                clr_underrun = ($urandom_range(199) == 0);
                if (--gap == 0) begin
                    AUD_LRCK = ~AUD_LRCK;
                    gap = $urandom_range(10, 3);
                end
                tick(1);
            end
        end
        in_valid     = 1'b0;
        clr_underrun = 1'b0;

        // Starve to a stopped, empty FIFO, then refill to 10 and reset mid-frame.
        for (int i = 0; i < 2 * DEPTH + 4; i++) begin
            AUD_LRCK = ~AUD_LRCK;
            tick(4);
        end
        check("starved level", 32'(fifo_level), 0);
        push_seq(16'h3000, 10);
        tick(1);
        check("refill level", 32'(fifo_level), 10);
        @(posedge AUD_XCK);
        #3;
        reset_n = 1'b0;
        #1;
        check("async rst level", 32'(fifo_level), 0);
        check("async rst audio", 32'(audiodata), 0);
        check("async rst count", 32'(underrun_cnt), 0);
        AUD_LRCK = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);

`ifdef AUDIO_VOLUME_EN
        vol_shift = 3'd2;
        in_valid = 1'b1; in_data = 16'h8000; tick(1);
        in_data = 16'h4000; tick(1);
        push_seq(16'h0000, 6);
        AUD_LRCK = 1'b1;
        tick(2);
        check("vol negative", 32'(audiodata), 32'hE000);
        tick(2);
        AUD_LRCK = 1'b0;
        tick(2);
        check("vol positive", 32'(audiodata), 32'h1000);
        tick(2);
`endif

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
